// File: rtl/regfile_store16_pkg.sv
// Shared sizes, state encoding and bus-slice rule for the 16x16 register file store.
package regfile_store16_pkg;

   localparam int NUM_REGS  = 16;
   localparam int DATA_W    = 16;
   localparam int REG_IDX_W = 4;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } state_t;

   // Register k occupies bits [16k+15:16k] of the flattened bus.
   function automatic int slice_base(input int k);
      return k * DATA_W;
   endfunction

endpackage

// File: rtl/regfile_store16_reg16.sv
// One storage word: sync reset, then sync clear, then load enable.
module reg16
   import regfile_store16_pkg::*;
#(
   parameter int WIDTH = DATA_W
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_en,
   input  logic             i_clr,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH-1:0] r_q;

   // Clear wins over load so the sweep always zeroes its target word.
   always_ff @(posedge i_clk) begin
      if (i_rst)
         r_q <= '0;
      else if (i_clr)
         r_q <= '0;
      else if (i_en)
         r_q <= i_d;
   end

   assign o_q = r_q;

endmodule

// File: rtl/regfile_store16.sv
// Register file storage: 16 words, one write per cycle, flattened read bus,
// and a one-word-per-cycle clear sweep with busy/done handshake.
//
//  state    | meaning
//  ---------+-----------------------------------------------------------
//  ST_IDLE  | writes accepted, clrReq sampled
//  ST_CLEAR | zeroing reg[cnt] each edge, writes dropped (err flagged)
module regfile_store16
   import regfile_store16_pkg::*;
#(
   parameter int NUM_REGS = regfile_store16_pkg::NUM_REGS,
   parameter int DATA_W   = regfile_store16_pkg::DATA_W,
   parameter bit BYPASS   = 1'b1
) (
   input  logic                       i_clk,
   input  logic                       i_rst,
   input  logic                       i_writeEn,
   input  logic [REG_IDX_W-1:0]       i_writeReg,
   input  logic [DATA_W-1:0]          i_writeData,
   input  logic                       i_clrReq,
   output logic [NUM_REGS*DATA_W-1:0] o_regBus,
   output logic                       o_busy,
   output logic                       o_done,
   output logic                       o_err
);

   state_t               r_state;
   state_t               w_state_nx;
   logic [REG_IDX_W-1:0] r_cnt;
   logic [REG_IDX_W-1:0] w_cnt_nx;
   logic                 r_done;
   logic                 w_done_nx;
   logic                 w_busy;
   logic                 w_wr_ok;
   logic [NUM_REGS-1:0]  w_wr_en;
   logic [NUM_REGS-1:0]  w_clr_en;
   logic [DATA_W-1:0]    w_q [NUM_REGS];

   // State, sweep counter and done pulse.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nx;
         r_cnt   <= w_cnt_nx;
         r_done  <= w_done_nx;
      end
   end

   // Next state: clrReq only matters in IDLE; the sweep exits after reg15.
   always_comb begin
      w_state_nx = r_state;
      w_cnt_nx   = r_cnt;
      w_done_nx  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (i_clrReq) begin
               w_state_nx = ST_CLEAR;
               w_cnt_nx   = '0;
            end
         end
         ST_CLEAR: begin
            w_cnt_nx = r_cnt + REG_IDX_W'(1);
            if (r_cnt == REG_IDX_W'(NUM_REGS - 1)) begin
               w_state_nx = ST_IDLE;
               w_cnt_nx   = '0;
               w_done_nx  = 1'b1;
            end
         end
         default: begin
            w_state_nx = ST_IDLE;
            w_cnt_nx   = '0;
         end
      endcase
   end

   assign w_busy  = (r_state == ST_CLEAR);
   assign w_wr_ok = i_writeEn && !w_busy;

   assign o_busy = w_busy;
   assign o_done = r_done;
   assign o_err  = i_writeEn && w_busy;

   for (genvar k = 0; k < NUM_REGS; k++) begin : g_reg
      assign w_wr_en[k]  = w_wr_ok && (i_writeReg == REG_IDX_W'(k));
      assign w_clr_en[k] = w_busy && (r_cnt == REG_IDX_W'(k));

      reg16 #(.WIDTH(DATA_W)) u_reg (
         .i_clk (i_clk),
         .i_rst (i_rst),
         .i_en  (w_wr_en[k]),
         .i_clr (w_clr_en[k]),
         .i_d   (i_writeData),
         .o_q   (w_q[k])
      );

      // Bypass only applies to accepted writes, so nothing shows during a sweep.
      assign o_regBus[slice_base(k) +: DATA_W] =
         (BYPASS && w_wr_en[k]) ? i_writeData : w_q[k];
   end

endmodule

// File: tb/tb_regfile_store16.sv
// Directed bench for regfile_store16: a bypassing and a non-bypassing instance
// share all inputs; each is compared against hand-computed values.
module tb_regfile_store16;

   logic         clk = 1'b0;
   logic         rst;
   logic         we;
   logic [3:0]   wreg;
   logic [15:0]  wdata;
   logic         clr;
   logic [255:0] bus_b,  bus_n;
   logic         busy_b, busy_n, done_b, done_n, err_b, err_n;

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   regfile_store16 #(.BYPASS(1'b1)) dut (
      .i_clk(clk), .i_rst(rst), .i_writeEn(we), .i_writeReg(wreg),
      .i_writeData(wdata), .i_clrReq(clr), .o_regBus(bus_b),
      .o_busy(busy_b), .o_done(done_b), .o_err(err_b)
   );

   regfile_store16 #(.BYPASS(1'b0)) dut_nb (
      .i_clk(clk), .i_rst(rst), .i_writeEn(we), .i_writeReg(wreg),
      .i_writeData(wdata), .i_clrReq(clr), .o_regBus(bus_n),
      .o_busy(busy_n), .o_done(done_n), .o_err(err_n)
   );

   typedef struct {
      logic        we;
      logic [3:0]  wreg;
      logic [15:0] wdata;
      int          idx;
      logic [15:0] exp_byp;
      logic [15:0] exp_nb;
   } vec_t;

   vec_t vecs[8];

   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
      n_total++;
      if (act === exp)
         n_pass++;
      else
         $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic fill_ffff();
      for (int k = 0; k < 16; k++) begin
         we    = 1'b1;
         wreg  = 4'(k);
         wdata = 16'hFFFF;
         tick();
      end
      we = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [255:0] exp_bus;

      vecs[0] = '{1'b1, 4'd3,  16'hBEEF, 3,  16'hBEEF, 16'h0000};
      vecs[1] = '{1'b1, 4'd15, 16'h1234, 15, 16'h1234, 16'h0000};
      vecs[2] = '{1'b0, 4'd0,  16'h0000, 3,  16'hBEEF, 16'hBEEF};
      vecs[3] = '{1'b0, 4'd0,  16'h0000, 15, 16'h1234, 16'h1234};
      vecs[4] = '{1'b1, 4'd7,  16'hA5A5, 7,  16'hA5A5, 16'h0000};
      vecs[5] = '{1'b0, 4'd0,  16'h0000, 7,  16'hA5A5, 16'hA5A5};
      vecs[6] = '{1'b1, 4'd3,  16'h0001, 4,  16'h0000, 16'h0000};
      vecs[7] = '{1'b0, 4'd0,  16'h0000, 3,  16'h0001, 16'h0001};

      rst = 1'b1; we = 1'b0; wreg = '0; wdata = '0; clr = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      @(negedge clk);
      chk("reset_bus", bus_b, '0);
      chk("reset_busy", 256'(busy_b), 256'(0));
      chk("reset_done", 256'(done_b), 256'(0));
      chk("reset_err", 256'(err_b), 256'(0));
      tick();

      // Simple writes and bypass visibility
      for (int i = 0; i < 8; i++) begin
         we    = vecs[i].we;
         wreg  = vecs[i].wreg;
         wdata = vecs[i].wdata;
         @(negedge clk);
         chk($sformatf("vec%0d_byp_slice", i), 256'(bus_b[vecs[i].idx*16 +: 16]), 256'(vecs[i].exp_byp));
         chk($sformatf("vec%0d_nb_slice", i), 256'(bus_n[vecs[i].idx*16 +: 16]), 256'(vecs[i].exp_nb));
         chk($sformatf("vec%0d_err", i), 256'(err_b), 256'(0));
         tick();
      end
      we = 1'b0;
      @(negedge clk);
      exp_bus = '0;
      exp_bus[3*16 +: 16]  = 16'h0001;
      exp_bus[7*16 +: 16]  = 16'hA5A5;
      exp_bus[15*16 +: 16] = 16'h1234;
      chk("after_writes_bus_byp", bus_b, exp_bus);
      chk("after_writes_bus_nb", bus_n, exp_bus);
      tick();

      // Full sweep with a dropped write and an ignored clrReq
      fill_ffff();
      @(negedge clk);
      chk("filled_bus", bus_b, {256{1'b1}});
      clr = 1'b1;
      tick();
      clr = 1'b0;
      for (int n = 1; n <= 17; n++) begin
         we    = (n == 4);
         wreg  = 4'd9;
         wdata = 16'h5555;
         clr   = (n == 6);
         @(negedge clk);
         for (int k = 0; k < 16; k++)
            exp_bus[k*16 +: 16] = (n >= 2 + k) ? 16'h0000 : 16'hFFFF;
         chk($sformatf("sweep_bus_byp c%0d", n), bus_b, exp_bus);
         chk($sformatf("sweep_bus_nb c%0d", n), bus_n, exp_bus);
         chk($sformatf("sweep_busy c%0d", n), 256'(busy_b), 256'(n <= 16));
         chk($sformatf("sweep_done c%0d", n), 256'(done_b), 256'(n == 17));
         chk($sformatf("sweep_err c%0d", n), 256'(err_b), 256'(n == 4));
         tick();
      end
      we = 1'b0; clr = 1'b0;
      @(negedge clk);
      chk("post_sweep_bus", bus_b, '0);
      chk("post_sweep_done", 256'(done_b), 256'(0));
      chk("post_sweep_busy", 256'(busy_b), 256'(0));
      tick();

      // Reset in the middle of a sweep
      fill_ffff();
      clr = 1'b1;
      tick();
      clr = 1'b0;
      for (int n = 1; n <= 7; n++)
         tick();
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_busy_before", 256'(busy_b), 256'(1));
      tick();
      rst = 1'b0;
      for (int n = 9; n <= 28; n++) begin
         @(negedge clk);
         chk($sformatf("midrst_bus c%0d", n), bus_b, '0);
         chk($sformatf("midrst_busy c%0d", n), 256'(busy_b), 256'(0));
         chk($sformatf("midrst_done c%0d", n), 256'(done_b), 256'(0));
         tick();
      end

      // clrReq together with a write in IDLE
      clr = 1'b1; we = 1'b1; wreg = 4'd0; wdata = 16'h0042;
      @(negedge clk);
      chk("clrwr_t_byp", 256'(bus_b[15:0]), 256'(16'h0042));
      chk("clrwr_t_nb", 256'(bus_n[15:0]), 256'(16'h0000));
      tick();
      clr = 1'b0; we = 1'b0;
      @(negedge clk);
      chk("clrwr_t1_byp", 256'(bus_b[15:0]), 256'(16'h0042));
      chk("clrwr_t1_nb", 256'(bus_n[15:0]), 256'(16'h0042));
      chk("clrwr_t1_busy", 256'(busy_b), 256'(1));
      tick();
      @(negedge clk);
      chk("clrwr_t2_byp", 256'(bus_b[15:0]), 256'(16'h0000));
      chk("clrwr_t2_nb", 256'(bus_n[15:0]), 256'(16'h0000));
      for (int n = 3; n <= 17; n++) begin
         tick();
         @(negedge clk);
      end
      chk("clrwr_t17_done", 256'(done_b), 256'(1));
      chk("clrwr_t17_busy", 256'(busy_b), 256'(0));

      // New clrReq accepted in the done cycle
      clr = 1'b1;
      tick();
      clr = 1'b0;
      @(negedge clk);
      chk("reclr_busy", 256'(busy_b), 256'(1));
      chk("reclr_done", 256'(done_b), 256'(0));
      for (int n = 0; n < 17; n++)
         tick();
      @(negedge clk);
      chk("reclr_end_busy", 256'(busy_b), 256'(0));

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/regfile_store16.md
# regfile_store16

Storage half of the 16-entry, 16-bit register file. Holds sixteen 16-bit registers, accepts one write per cycle, and drives all register contents as one flattened 256-bit bus. The downstream 16:1 16-bit read multiplexers select one register from that bus per read port. It also contains a clear sequencer that zeroes the file one register per cycle on request, with a busy/done handshake toward the control unit.

## Interface
Parameters
- NUM_REGS, 16, number of registers; fixed at 16 for this design.
- DATA_W, 16, register width in bits.
- BYPASS, 1, when 1 the write data appears on regBus in the same cycle as the write; when 0 regBus shows registered contents only.

Ports
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- writeEn  in  1  write request this cycle.
- writeReg  in  4  destination register index.
- writeData  in  16  data to write.
- clrReq  in  1  start a clear sweep; sampled only in IDLE.
- regBus  out  256  flattened register contents; register k occupies bits [16k+15:16k].
- busy  out  1  high while the clear sweep runs.
- done  out  1  one-cycle pulse after the sweep completes.
- err  out  1  high in any cycle where writeEn=1 while busy=1.

## Operation
- Reset: all registers go to 0x0000, the state machine goes to IDLE, and the counter goes to 0. After reset, regBus=0, busy=0, done=0 and err=0.
- State machine has two states, IDLE and CLEAR.
  - IDLE → CLEAR when clrReq=1 at an edge. The counter loads 0.
  - In CLEAR, each edge zeroes reg[cnt] and increments cnt.
  - When cnt==15, the edge zeroes reg15 and returns the state to IDLE. The done register is set for exactly one cycle.
  - clrReq is ignored while in CLEAR; a sweep cannot be retriggered or extended.
- Write in IDLE: when writeEn=1, the edge loads reg[writeReg] ← writeData.
- Write in CLEAR: the write is dropped and err=1 in that cycle. err is combinational: writeEn & busy.
- clrReq and writeEn together in IDLE: the write commits at that edge. The sweep starts next cycle and later zeroes the written value.
- Bypass (BYPASS=1): while in IDLE with writeEn=1, the regBus slice for writeReg shows writeData combinationally. All other slices show their registers. No bypass occurs in CLEAR because writes are dropped there.
- Reset mid-sweep: rst has priority over everything. All registers are zeroed, the state returns to IDLE, and done is not pulsed.
- No arithmetic beyond the 4-bit counter. The counter never wraps in use because the exit at 15 precedes the wrap.

## Timing
- Write latency: data is registered at the edge of the write cycle and visible on regBus from the next cycle. With BYPASS=1 it is also visible in the write cycle itself.
- Clear timing, with clrReq sampled at edge t:
  - busy is high for cycles t+1 through t+16.
  - reg k reads zero from cycle t+2+k onward.
  - done is high in cycle t+17 only, and busy is low in that cycle.
- busy and done are registered outputs; err and the bypassed regBus slice are combinational.
- A new clrReq is accepted in the done cycle (t+17), since the state is IDLE then.

## Structure
- Shared package holds:
  - NUM_REGS, DATA_W, REG_IDX_W=4;
  - the state encoding (IDLE=1'b0, CLEAR=1'b1);
  - the bus-slice rule (base index = 16·k).
- Sub-module reg16: a 16-bit register with load enable, sync clear and sync reset. It is instantiated 16× via generate; its enable and clear are decoded from writeReg and cnt.
- The top level holds the state machine, the counter, the decode logic, and the bypass mux per slice.

## Test plan
- Reset, then write reg3 ← 0xBEEF and reg15 ← 0x1234 → regBus[63:48]=0xBEEF and regBus[255:240]=0x1234; all other slices 0x0000; err=0.
- BYPASS=1, write reg7 ← 0xA5A5 → regBus[127:112]=0xA5A5 in the same cycle. With BYPASS=0 → 0xA5A5 appears one cycle later.
- Fill all 16 registers with 0xFFFF, pulse clrReq at edge t:
  - busy is high for 16 cycles;
  - reg0 is zero at t+2 and reg15 is zero at t+17;
  - done pulses at t+17 only.
- During the sweep, writeEn=1 to reg9 with 0x5555 → err=1 that cycle; reg9 stays 0 after the sweep; no bypass is shown.
- Assert rst at cycle t+8 of a sweep → regBus=0, busy=0, and done stays 0 in all following cycles.
- clrReq and a write of reg0 ← 0x0042 in the same IDLE cycle → reg0 reads 0x0042 for one cycle, then 0x0000 after the sweep's first edge; the sweep proceeds normally.
